// File: rtl/round_ctrl_pkg.sv
// Shared constants, FSM encoding and gesture helpers for the round controller.
package round_ctrl_pkg;

    localparam logic [1:0] ROCK     = 2'd0;
    localparam logic [1:0] SCISSORS = 2'd1;
    localparam logic [1:0] PAPER    = 2'd2;

    localparam logic [3:0] KEY_NONE = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REVEAL = 2'd1,
        ST_HOLD   = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    // True when exactly one button of a player's {paper, scissors, rock} set is high.
    function automatic logic is_single(input logic [2:0] btn);
        return (btn == 3'b001) || (btn == 3'b010) || (btn == 3'b100);
    endfunction

    function automatic logic [1:0] btn_idx(input logic [2:0] btn);
        logic [1:0] idx;
        case (btn)
            3'b010:  idx = SCISSORS;
            3'b100:  idx = PAPER;
            default: idx = ROCK;
        endcase
        return idx;
    endfunction

    // Round code handed to the scorer: 3*A + B + 1, always in 1..9.
    function automatic logic [3:0] round_key(input logic [1:0] a_idx, input logic [1:0] b_idx);
        return ({2'b00, a_idx} * 4'd3) + {2'b00, b_idx} + 4'd1;
    endfunction

endpackage

// File: rtl/round_ctrl_debounce.sv
// Two-flop synchroniser followed by a down-counting debouncer for one raw button.
module debounce #(
    parameter logic [15:0] DEB_CNT = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic        meta;
    logic        sync;
    logic [15:0] cnt;

    // The counter reloads whenever the synchronised sample agrees with the
    // accepted level, so the level only moves after DEB_CNT disagreeing samples in a row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            dout <= 1'b0;
            cnt  <= 16'd0;
        end else begin
            meta <= din;
            sync <= meta;
            if (sync == dout) begin
                cnt <= DEB_CNT - 16'd1;
            end else if (cnt == 16'd0) begin
                dout <= sync;
                cnt  <= DEB_CNT - 16'd1;
            end else begin
                cnt <= cnt - 16'd1;
            end
        end
    end

endmodule

// File: rtl/round_ctrl.sv
// Round controller: captures one throw per player, pulses start with the
// round code, waits for all buttons to be released, and parks once the match ends.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | capturing throws, key = none
//   ST_REVEAL | one-cycle start pulse, key valid
//   ST_HOLD   | key held until every button is released
//   ST_LOCK   | match over, only reset leaves
module round_ctrl
    import round_ctrl_pkg::*;
#(
    parameter logic [15:0] DEB_CNT = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_a,
    input  logic [2:0] btn_b,
    input  logic [1:0] game_over,
    output logic [3:0] key,
    output logic       start,
    output logic       a_locked,
    output logic       b_locked
);

    logic [5:0] btn_all;
    logic [5:0] deb_all;
    logic [2:0] deb_a;
    logic [2:0] deb_b;

    state_t     state, state_n;
    logic       a_locked_n, b_locked_n;
    logic [1:0] a_idx, a_idx_n;
    logic [1:0] b_idx, b_idx_n;

    assign btn_all = {btn_b, btn_a};
    assign deb_a   = deb_all[2:0];
    assign deb_b   = deb_all[5:3];

    for (genvar g = 0; g < 6; g++) begin : g_deb
        debounce #(.DEB_CNT(DEB_CNT)) u_deb (
            .clk  (clk),
            .rst  (rst),
            .din  (btn_all[g]),
            .dout (deb_all[g])
        );
    end

    // State, lock flags and captured indices.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            a_locked <= 1'b0;
            b_locked <= 1'b0;
            a_idx    <= ROCK;
            b_idx    <= ROCK;
        end else begin
            state    <= state_n;
            a_locked <= a_locked_n;
            b_locked <= b_locked_n;
            a_idx    <= a_idx_n;
            b_idx    <= b_idx_n;
        end
    end

    // Next-state, capture and output decode; key and start come straight from
    // the state so reset clears them without waiting for a clock.
    always_comb begin
        state_n    = state;
        a_locked_n = a_locked;
        b_locked_n = b_locked;
        a_idx_n    = a_idx;
        b_idx_n    = b_idx;
        start      = 1'b0;
        key        = KEY_NONE;
        case (state)
            ST_IDLE: begin
                if (game_over != 2'b00) begin
                    state_n    = ST_LOCK;
                    a_locked_n = 1'b0;
                    b_locked_n = 1'b0;
                end else begin
                    if (!a_locked && is_single(deb_a)) begin
                        a_locked_n = 1'b1;
                        a_idx_n    = btn_idx(deb_a);
                    end
                    if (!b_locked && is_single(deb_b)) begin
                        b_locked_n = 1'b1;
                        b_idx_n    = btn_idx(deb_b);
                    end
                    if (a_locked_n && b_locked_n) begin
                        state_n = ST_REVEAL;
                    end
                end
            end
            ST_REVEAL: begin
                start   = 1'b1;
                key     = round_key(a_idx, b_idx);
                state_n = ST_HOLD;
            end
            ST_HOLD: begin
                key = round_key(a_idx, b_idx);
                if (game_over != 2'b00) begin
                    state_n    = ST_LOCK;
                    a_locked_n = 1'b0;
                    b_locked_n = 1'b0;
                end else if (deb_all == 6'b000000) begin
                    state_n    = ST_IDLE;
                    a_locked_n = 1'b0;
                    b_locked_n = 1'b0;
                end
            end
            ST_LOCK: begin
                a_locked_n = 1'b0;
                b_locked_n = 1'b0;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with a short debounce window.
module tb_round_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] btn_a;
    logic [2:0] btn_b;
    logic [1:0] game_over;
    logic [3:0] key;
    logic       start;
    logic       a_locked;
    logic       b_locked;

    int checks;
    int errors;
    int start_cnt;

    round_ctrl #(.DEB_CNT(16'd4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_a     (btn_a),
        .btn_b     (btn_b),
        .game_over (game_over),
        .key       (key),
        .start     (start),
        .a_locked  (a_locked),
        .b_locked  (b_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start) start_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_start(input int budget, output bit seen, output bit pre_a, output bit pre_b);
        seen  = 1'b0;
        pre_a = a_locked;
        pre_b = b_locked;
        for (int i = 0; i < budget && !seen; i++) begin
            pre_a = a_locked;
            pre_b = b_locked;
            tick(1);
            if (start) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst       = 1'b0;
        btn_a     = 3'b000;
        btn_b     = 3'b000;
        game_over = 2'b00;
        tick(3);
        checks++; if (key !== 4'h0)    begin errors++; $display("FAIL reset_key got %h want 0", key); end
        checks++; if (start !== 1'b0)  begin errors++; $display("FAIL reset_start got %b want 0", start); end
        checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL reset_a_locked got %b want 0", a_locked); end
        checks++; if (b_locked !== 1'b0) begin errors++; $display("FAIL reset_b_locked got %b want 0", b_locked); end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_basic;
        bit seen, pa, pb;
        int base;
        base  = start_cnt;
        btn_a = 3'b100;
        tick(10);
        checks++; if (a_locked !== 1'b1) begin errors++; $display("FAIL basic_a_lock got %b want 1", a_locked); end
        checks++; if (b_locked !== 1'b0) begin errors++; $display("FAIL basic_b_unlocked got %b want 0", b_locked); end
        checks++; if (start_cnt - base !== 0) begin errors++; $display("FAIL basic_early_start got %0d want 0", start_cnt - base); end
        btn_b = 3'b001;
        wait_start(20, seen, pa, pb);
        checks++; if (!seen) begin errors++; $display("FAIL basic_start_timeout got none want pulse"); end
        checks++; if (key !== 4'h7) begin errors++; $display("FAIL basic_key got %h want 7", key); end
        checks++; if ({a_locked, b_locked} !== 2'b11) begin errors++; $display("FAIL basic_locks got %b want 11", {a_locked, b_locked}); end
        tick(1);
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b want 0", start); end
        checks++; if (key !== 4'h7) begin errors++; $display("FAIL basic_hold_key got %h want 7", key); end
        btn_a = 3'b000;
        tick(12);
        checks++; if (key !== 4'h7) begin errors++; $display("FAIL basic_partial_release_key got %h want 7", key); end
        btn_b = 3'b000;
        tick(12);
        checks++; if (key !== 4'h0) begin errors++; $display("FAIL basic_release_key got %h want 0", key); end
        checks++; if ({a_locked, b_locked} !== 2'b00) begin errors++; $display("FAIL basic_release_locks got %b want 00", {a_locked, b_locked}); end
        checks++; if (start_cnt - base !== 1) begin errors++; $display("FAIL basic_pulse_count got %0d want 1", start_cnt - base); end
    endtask

    task automatic test_same_cycle;
        bit seen, pa, pb;
        int base;
        base  = start_cnt;
        btn_a = 3'b010;
        btn_b = 3'b010;
        wait_start(20, seen, pa, pb);
        checks++; if (!seen) begin errors++; $display("FAIL same_start_timeout got none want pulse"); end
        checks++; if ({pa, pb} !== 2'b00) begin errors++; $display("FAIL same_prelocks got %b want 00", {pa, pb}); end
        checks++; if ({a_locked, b_locked} !== 2'b11) begin errors++; $display("FAIL same_locks got %b want 11", {a_locked, b_locked}); end
        checks++; if (key !== 4'h5) begin errors++; $display("FAIL same_key got %h want 5", key); end
        btn_a = 3'b000;
        btn_b = 3'b000;
        tick(12);
        checks++; if (start_cnt - base !== 1) begin errors++; $display("FAIL same_pulse_count got %0d want 1", start_cnt - base); end
        checks++; if (key !== 4'h0) begin errors++; $display("FAIL same_release_key got %h want 0", key); end
    endtask

    task automatic test_invalid;
        bit seen, pa, pb;
        int base;
        base  = start_cnt;
        btn_a = 3'b101;
        btn_b = 3'b010;
        tick(12);
        checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL invalid_a_lock got %b want 0", a_locked); end
        checks++; if (b_locked !== 1'b1) begin errors++; $display("FAIL invalid_b_lock got %b want 1", b_locked); end
        checks++; if (start_cnt - base !== 0) begin errors++; $display("FAIL invalid_no_start got %0d want 0", start_cnt - base); end
        btn_a = 3'b001;
        wait_start(20, seen, pa, pb);
        checks++; if (!seen) begin errors++; $display("FAIL invalid_start_timeout got none want pulse"); end
        checks++; if (key !== 4'h2) begin errors++; $display("FAIL invalid_key got %h want 2", key); end
        btn_a = 3'b000;
        btn_b = 3'b000;
        tick(12);
    endtask

    task automatic test_glitch_relock;
        bit seen, pa, pb;
        btn_a = 3'b001;
        tick(2);
        btn_a = 3'b000;
        tick(12);
        checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL glitch_a_lock got %b want 0", a_locked); end
        btn_a = 3'b010;
        tick(10);
        checks++; if (a_locked !== 1'b1) begin errors++; $display("FAIL relock_a_lock got %b want 1", a_locked); end
        btn_a = 3'b001;
        tick(10);
        btn_b = 3'b001;
        wait_start(20, seen, pa, pb);
        checks++; if (!seen) begin errors++; $display("FAIL relock_start_timeout got none want pulse"); end
        checks++; if (key !== 4'h4) begin errors++; $display("FAIL relock_key got %h want 4", key); end
        btn_a = 3'b000;
        btn_b = 3'b000;
        tick(12);
    endtask

    task automatic test_game_over;
        bit seen, pa, pb;
        int base;
        btn_a = 3'b001;
        btn_b = 3'b100;
        wait_start(20, seen, pa, pb);
        checks++; if (!seen) begin errors++; $display("FAIL over_start_timeout got none want pulse"); end
        checks++; if (key !== 4'h3) begin errors++; $display("FAIL over_key got %h want 3", key); end
        tick(1);
        game_over = 2'b10;
        tick(1);
        checks++; if (key !== 4'h0) begin errors++; $display("FAIL over_lock_key got %h want 0", key); end
        checks++; if ({a_locked, b_locked} !== 2'b00) begin errors++; $display("FAIL over_lock_locks got %b want 00", {a_locked, b_locked}); end
        game_over = 2'b00;
        btn_a = 3'b000;
        btn_b = 3'b000;
        tick(12);
        base  = start_cnt;
        btn_a = 3'b001;
        btn_b = 3'b001;
        tick(20);
        checks++; if (start_cnt - base !== 0) begin errors++; $display("FAIL over_no_start got %0d want 0", start_cnt - base); end
        checks++; if ({a_locked, b_locked} !== 2'b00) begin errors++; $display("FAIL over_ignore_locks got %b want 00", {a_locked, b_locked}); end
        btn_a = 3'b000;
        btn_b = 3'b000;
        tick(12);
    endtask

    task automatic test_reset_mid;
        bit seen, pa, pb;
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        btn_a = 3'b001;
        btn_b = 3'b100;
        wait_start(20, seen, pa, pb);
        checks++; if (!seen) begin errors++; $display("FAIL mid_start_timeout got none want pulse"); end
        tick(1);
        checks++; if (key !== 4'h3) begin errors++; $display("FAIL mid_hold_key got %h want 3", key); end
        #1 rst = 1'b0;
        #1;
        checks++; if (key !== 4'h0) begin errors++; $display("FAIL mid_async_key got %h want 0", key); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL mid_async_start got %b want 0", start); end
        checks++; if ({a_locked, b_locked} !== 2'b00) begin errors++; $display("FAIL mid_async_locks got %b want 00", {a_locked, b_locked}); end
        btn_a = 3'b000;
        btn_b = 3'b000;
        tick(2);
        rst = 1'b1;
        tick(2);
        btn_a = 3'b010;
        btn_b = 3'b100;
        wait_start(20, seen, pa, pb);
        checks++; if (!seen) begin errors++; $display("FAIL mid_next_timeout got none want pulse"); end
        checks++; if (key !== 4'h6) begin errors++; $display("FAIL mid_next_key got %h want 6", key); end
        btn_a = 3'b000;
        btn_b = 3'b000;
        tick(12);
        checks++; if (key !== 4'h0) begin errors++; $display("FAIL mid_next_release got %h want 0", key); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        start_cnt = 0;
        rst       = 1'b0;
        btn_a     = 3'b000;
        btn_b     = 3'b000;
        game_over = 2'b00;
        test_reset();
        test_basic();
        test_same_cycle();
        test_invalid();
        test_glitch_relock();
        test_game_over();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
